// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for the VGA output path.
// Two counters (x, y) advance on system-clock edges where pix_en is high.
// Every output is registered and decoded from the next counter values, so
// sync, blanking and the coordinates always line up in the same cycle.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset (priority over pix_en)
//   pix_en      in   one-cycle pixel tick (clock enable, never a clock)
//   hsync       out  horizontal sync, asserted level = SYNC_POL
//   vsync       out  vertical sync, asserted level = SYNC_POL
//   video_on    out  high inside the visible region
//   x           out  horizontal count 0..H_TOTAL-1
//   y           out  line count 0..V_TOTAL-1
//   line_start  out  one-clk strobe when x has just wrapped to 0
//   frame_start out  one-clk strobe when (x,y) has just wrapped to (0,0)
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned CW = 10;
    // One extra bit so window bounds equal to 1024 still compare correctly.
    localparam int unsigned EW = CW + 1;

    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_HI = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_HI = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          wrap;
    logic [EW-1:0] x_ext;
    logic [EW-1:0] y_ext;

    // Counter advance and decode of the values the counters are about to hold.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        wrap = 1'b0;
        if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d  = '0;
                wrap = 1'b1;
                y_d  = (y_q == V_LAST) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end

        x_ext = {1'b0, x_d};
        y_ext = {1'b0, y_d};

        hsync_d = ((x_ext >= EW'(H_SYNC_LO)) && (x_ext < EW'(H_SYNC_HI)))
                  ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((y_ext >= EW'(V_SYNC_LO)) && (y_ext < EW'(V_SYNC_HI)))
                  ? SYNC_POL : ~SYNC_POL;
        video_on_d    = (x_ext < EW'(H_ACTIVE)) && (y_ext < EW'(V_ACTIVE));
        // Strobes only fire on a tick that wrapped x, so idle clks give 0.
        line_start_d  = wrap;
        frame_start_d = wrap && (y_d == '0);
    end

    // State and output registers; reset parks at the last pixel of a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 build, an inverted-polarity build,
// and a tiny 15x10 raster used for whole-frame checks.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    logic       d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
    logic [9:0] d_x, d_y;
    logic       p_hsync, p_vsync, p_video_on, p_line_start, p_frame_start;
    logic [9:0] p_x, p_y;
    logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
    logic [9:0] s_x, s_y;

    int errors = 0;
    int checks = 0;

    vga_sync_gen u_dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on),
        .x(d_x), .y(d_y), .line_start(d_line_start), .frame_start(d_frame_start)
    );

    vga_sync_gen #(.SYNC_POL(1'b1)) u_pol (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hsync(p_hsync), .vsync(p_vsync), .video_on(p_video_on),
        .x(p_x), .y(p_y), .line_start(p_line_start), .frame_start(p_frame_start)
    );

    // 15 x 10 raster: H 8+2+3+2, V 6+1+2+1; hsync x=10..12, vsync y=7..8.
    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
        .x(s_x), .y(s_y), .line_start(s_line_start), .frame_start(s_frame_start)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1; pix_en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_en = 1'b1;
        step();
        checks++; if (d_x !== 10'd799) begin errors++; $display("FAIL reset_x got %0d exp 799", d_x); end
        checks++; if (d_y !== 10'd524) begin errors++; $display("FAIL reset_y got %0d exp 524", d_y); end
        checks++; if (d_video_on !== 1'b0) begin errors++; $display("FAIL reset_video_on got %b exp 0", d_video_on); end
        checks++; if (d_hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", d_hsync); end
        checks++; if (d_vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", d_vsync); end
        checks++; if (d_line_start !== 1'b0) begin errors++; $display("FAIL reset_line_start got %b exp 0", d_line_start); end
        checks++; if (d_frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", d_frame_start); end
        checks++; if (p_hsync !== 1'b0) begin errors++; $display("FAIL reset_pol_hsync got %b exp 0", p_hsync); end
        checks++; if (p_vsync !== 1'b0) begin errors++; $display("FAIL reset_pol_vsync got %b exp 0", p_vsync); end
        checks++; if (s_x !== 10'd14 || s_y !== 10'd9) begin errors++; $display("FAIL reset_small_xy got (%0d,%0d) exp (14,9)", s_x, s_y); end
    endtask

    task automatic test_first_tick();
        rst = 1'b0; pix_en = 1'b1;
        step();
        checks++; if (d_x !== 10'd0 || d_y !== 10'd0) begin errors++; $display("FAIL first_xy got (%0d,%0d) exp (0,0)", d_x, d_y); end
        checks++; if (d_video_on !== 1'b1) begin errors++; $display("FAIL first_video_on got %b exp 1", d_video_on); end
        checks++; if (d_line_start !== 1'b1) begin errors++; $display("FAIL first_line_start got %b exp 1", d_line_start); end
        checks++; if (d_frame_start !== 1'b1) begin errors++; $display("FAIL first_frame_start got %b exp 1", d_frame_start); end
        checks++; if (d_hsync !== 1'b1 || d_vsync !== 1'b1) begin errors++; $display("FAIL first_sync got h=%b v=%b exp 1 1", d_hsync, d_vsync); end
        checks++; if (p_hsync !== 1'b0 || p_vsync !== 1'b0) begin errors++; $display("FAIL first_pol_sync got h=%b v=%b exp 0 0", p_hsync, p_vsync); end
        step();
        checks++; if (d_x !== 10'd1) begin errors++; $display("FAIL second_x got %0d exp 1", d_x); end
        checks++; if (d_line_start !== 1'b0 || d_frame_start !== 1'b0) begin errors++; $display("FAIL second_strobes got ls=%b fs=%b exp 0 0", d_line_start, d_frame_start); end
    endtask

    // Runs from x=1 of line 0 through the wrap onto line 1.
    task automatic test_hsync_window();
        int ex; int xbad; int lo_cnt; int first_lo; int last_lo;
        int voff; int vbad; int pol_bad; int ls_cnt;
        ex = 1; xbad = 0; lo_cnt = 0; first_lo = -1; last_lo = -1;
        voff = 0; vbad = 0; pol_bad = 0; ls_cnt = 0;
        pix_en = 1'b1;
        for (int i = 0; i < 799; i++) begin
            step();
            ex = (ex == 799) ? 0 : ex + 1;
            if (d_x !== 10'(ex)) xbad++;
            if (d_hsync === 1'b0) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = ex;
                last_lo = ex;
            end
            if (p_hsync !== ~d_hsync) pol_bad++;
            if (d_video_on === 1'b0) voff++;
            if ((ex >= 640) != (d_video_on === 1'b0)) vbad++;
            if (d_line_start === 1'b1) ls_cnt++;
        end
        checks++; if (xbad != 0) begin errors++; $display("FAIL line_x_track got %0d bad exp 0", xbad); end
        checks++; if (lo_cnt != 96) begin errors++; $display("FAIL hsync_width got %0d exp 96", lo_cnt); end
        checks++; if (first_lo != 656) begin errors++; $display("FAIL hsync_first got %0d exp 656", first_lo); end
        checks++; if (last_lo != 751) begin errors++; $display("FAIL hsync_last got %0d exp 751", last_lo); end
        checks++; if (voff != 160 || vbad != 0) begin errors++; $display("FAIL hblank got off=%0d bad=%0d exp 160 0", voff, vbad); end
        checks++; if (pol_bad != 0) begin errors++; $display("FAIL pol_hsync_invert got %0d bad exp 0", pol_bad); end
        checks++; if (ls_cnt != 1) begin errors++; $display("FAIL line_start_count got %0d exp 1", ls_cnt); end
        checks++; if (d_x !== 10'd0 || d_y !== 10'd1) begin errors++; $display("FAIL line_wrap_xy got (%0d,%0d) exp (0,1)", d_x, d_y); end
        checks++; if (d_line_start !== 1'b1 || d_frame_start !== 1'b0) begin errors++; $display("FAIL line_wrap_strobes got ls=%b fs=%b exp 1 0", d_line_start, d_frame_start); end
    endtask

    // Whole frame on the small raster with pix_en held high.
    task automatic test_frame();
        int ex; int ey; int pos_bad; int vbad; int ls_cnt; int fs_cnt;
        int von; int vlo; int hlo; int vfirst; int vlast;
        ex = 14; ey = 9; pos_bad = 0; vbad = 0; ls_cnt = 0; fs_cnt = 0;
        von = 0; vlo = 0; hlo = 0; vfirst = -1; vlast = -1;
        reset_pulse();
        pix_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            step();
            if (ex == 14) begin ex = 0; ey = (ey == 9) ? 0 : ey + 1; end
            else ex = ex + 1;
            if (s_x !== 10'(ex) || s_y !== 10'(ey)) pos_bad++;
            if (s_video_on !== ((ex < 8) && (ey < 6))) vbad++;
            if (s_video_on === 1'b1) von++;
            if (s_line_start === 1'b1) ls_cnt++;
            if (s_frame_start === 1'b1) fs_cnt++;
            if (s_hsync === 1'b0) hlo++;
            if (s_vsync === 1'b0) begin
                vlo++;
                if (vfirst < 0) vfirst = ey * 15 + ex;
                vlast = ey * 15 + ex;
            end
        end
        checks++; if (pos_bad != 0) begin errors++; $display("FAIL frame_xy_track got %0d bad exp 0", pos_bad); end
        checks++; if (vbad != 0 || von != 48) begin errors++; $display("FAIL frame_video_on got count=%0d bad=%0d exp 48 0", von, vbad); end
        checks++; if (ls_cnt != 10) begin errors++; $display("FAIL frame_line_starts got %0d exp 10", ls_cnt); end
        checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_frame_starts got %0d exp 1", fs_cnt); end
        checks++; if (hlo != 30) begin errors++; $display("FAIL frame_hsync_ticks got %0d exp 30", hlo); end
        checks++; if (vlo != 30) begin errors++; $display("FAIL frame_vsync_ticks got %0d exp 30", vlo); end
        checks++; if (vfirst != 105 || vlast != 134) begin errors++; $display("FAIL vsync_window got %0d..%0d exp 105..134", vfirst, vlast); end
        step();
        checks++; if (s_x !== 10'd0 || s_y !== 10'd0 || s_frame_start !== 1'b1 || s_line_start !== 1'b1) begin
            errors++; $display("FAIL frame_wrap got (%0d,%0d) fs=%b ls=%b exp (0,0) 1 1", s_x, s_y, s_frame_start, s_line_start);
        end
    endtask

    // pix_en one clk in four: counters hold between ticks, strobes stay 1 clk.
    task automatic test_div4();
        int ex; int ey; int dx; int dy; int bad; int dbad; int ls_cnt;
        int fs_first; int fs_second; logic pe; logic els; logic efs;
        ex = 14; ey = 9; dx = 799; dy = 524; bad = 0; dbad = 0; ls_cnt = 0;
        fs_first = -1; fs_second = -1;
        reset_pulse();
        for (int c = 0; c < 604; c++) begin
            pe = (c % 4 == 0);
            pix_en = pe;
            step();
            els = 1'b0; efs = 1'b0;
            if (pe) begin
                if (ex == 14) begin
                    ex = 0; ey = (ey == 9) ? 0 : ey + 1;
                    els = 1'b1; efs = (ey == 0);
                end else ex = ex + 1;
                if (dx == 799) begin dx = 0; dy = (dy == 524) ? 0 : dy + 1; end
                else dx = dx + 1;
            end
            if (s_x !== 10'(ex) || s_y !== 10'(ey)) bad++;
            if (s_line_start !== els || s_frame_start !== efs) bad++;
            if (d_x !== 10'(dx) || d_y !== 10'(dy)) dbad++;
            if (s_line_start === 1'b1) ls_cnt++;
            if (s_frame_start === 1'b1) begin
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL div4_small_track got %0d bad exp 0", bad); end
        checks++; if (dbad != 0) begin errors++; $display("FAIL div4_default_track got %0d bad exp 0", dbad); end
        checks++; if (ls_cnt != 11) begin errors++; $display("FAIL div4_line_starts got %0d exp 11", ls_cnt); end
        checks++; if (fs_first != 0 || fs_second != 600) begin errors++; $display("FAIL div4_frame_period got %0d,%0d exp 0,600", fs_first, fs_second); end
        pix_en = 1'b0;
    endtask

    // Reset for one clk while inside the hsync window, with pix_en high.
    task automatic test_reset_mid();
        reset_pulse();
        pix_en = 1'b1;
        for (int i = 0; i < 701; i++) step();
        checks++; if (d_x !== 10'd700 || d_hsync !== 1'b0) begin errors++; $display("FAIL mid_pre got x=%0d h=%b exp 700 0", d_x, d_hsync); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (d_x !== 10'd799 || d_y !== 10'd524) begin errors++; $display("FAIL mid_reset_xy got (%0d,%0d) exp (799,524)", d_x, d_y); end
        checks++; if (d_video_on !== 1'b0 || d_hsync !== 1'b1 || d_vsync !== 1'b1) begin
            errors++; $display("FAIL mid_reset_levels got v=%b h=%b vs=%b exp 0 1 1", d_video_on, d_hsync, d_vsync);
        end
        checks++; if (d_line_start !== 1'b0 || d_frame_start !== 1'b0) begin errors++; $display("FAIL mid_reset_strobes got ls=%b fs=%b exp 0 0", d_line_start, d_frame_start); end
        checks++; if (p_hsync !== 1'b0 || s_x !== 10'd14 || s_y !== 10'd9) begin
            errors++; $display("FAIL mid_reset_others got ph=%b sx=%0d sy=%0d exp 0 14 9", p_hsync, s_x, s_y);
        end
        step();
        checks++; if (d_x !== 10'd0 || d_y !== 10'd0 || d_frame_start !== 1'b1 || d_video_on !== 1'b1) begin
            errors++; $display("FAIL mid_after got (%0d,%0d) fs=%b v=%b exp (0,0) 1 1", d_x, d_y, d_frame_start, d_video_on);
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_hsync_window();
        test_frame();
        test_div4();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
